// File: rtl/axi_ad7124_pkg.sv
// rtl/axi_ad7124_pkg.sv - command word layout, FSM states and run limits for the AD7124 command sequencer
package axi_ad7124_pkg;

    localparam int CMD_LAST_BIT   = 31;
    localparam int CMD_SEL_BIT    = 30;
    localparam int CMD_BOARD_LSB  = 27;
    localparam int CMD_BOARD_W    = 3;
    localparam int CMD_NBYTES_LSB = 24;
    localparam int CMD_NBYTES_W   = 3;
    localparam int MAX_BYTES      = 3;

    // A list that never sets LAST is cut off after this many words.
    localparam logic [11:0] MAX_RUN_WORDS = 12'd2048;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SEND,
        NEXT
    } cmd_state_t;

endpackage

// File: rtl/axi_ad7124_cmd_if.sv
// rtl/axi_ad7124_cmd_if.sv - per-board TC/RTD byte streams and BRAM read port of the command sequencer
interface axi_ad7124_cmd_if #(
    parameter int NUM_OF_BOARD = 6
);
    logic [NUM_OF_BOARD-1:0]      tc_sdo_valid;
    logic [NUM_OF_BOARD-1:0]      tc_sdo_ready;
    logic [NUM_OF_BOARD-1:0][7:0] tc_sdo_data;
    logic [NUM_OF_BOARD-1:0]      rtd_sdo_valid;
    logic [NUM_OF_BOARD-1:0]      rtd_sdo_ready;
    logic [NUM_OF_BOARD-1:0][7:0] rtd_sdo_data;

    logic        bram_clk;
    logic        bram_rst;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [12:0] bram_addr;
    logic [31:0] bram_wrdata;
    logic [31:0] bram_rddata;

    modport master (
        output tc_sdo_valid, tc_sdo_data, rtd_sdo_valid, rtd_sdo_data,
        output bram_clk, bram_rst, bram_en, bram_we, bram_addr, bram_wrdata,
        input  tc_sdo_ready, rtd_sdo_ready, bram_rddata
    );

    modport slave (
        input  tc_sdo_valid, tc_sdo_data, rtd_sdo_valid, rtd_sdo_data,
        input  bram_clk, bram_rst, bram_en, bram_we, bram_addr, bram_wrdata,
        output tc_sdo_ready, rtd_sdo_ready, bram_rddata
    );

endinterface

// File: rtl/axi_ad7124_cmd_demux.sv
// rtl/axi_ad7124_cmd_demux.sv - steers one valid/data/ready byte stream onto a board's TC or RTD channel
module axi_ad7124_cmd_demux #(
    parameter int NUM_OF_BOARD = 6
) (
    input  logic                         valid,
    input  logic [7:0]                   data,
    output logic                         ready,
    input  logic                         sel,
    input  logic [2:0]                   board,
    output logic [NUM_OF_BOARD-1:0]      tc_valid,
    output logic [NUM_OF_BOARD-1:0][7:0] tc_data,
    input  logic [NUM_OF_BOARD-1:0]      tc_ready,
    output logic [NUM_OF_BOARD-1:0]      rtd_valid,
    output logic [NUM_OF_BOARD-1:0][7:0] rtd_data,
    input  logic [NUM_OF_BOARD-1:0]      rtd_ready
);

    always_comb begin
        tc_valid  = '0;
        tc_data   = '0;
        rtd_valid = '0;
        rtd_data  = '0;
        ready     = 1'b0;
        for (int b = 0; b < NUM_OF_BOARD; b++) begin
            if (board == 3'(b)) begin
                if (sel) begin
                    rtd_valid[b] = valid;
                    rtd_data[b]  = data;
                    ready        = rtd_ready[b];
                end else begin
                    tc_valid[b] = valid;
                    tc_data[b]  = data;
                    ready       = tc_ready[b];
                end
            end
        end
    end

endmodule

// File: rtl/axi_ad7124_cmd.sv
// rtl/axi_ad7124_cmd.sv - fetches command words from BRAM and emits their payload bytes to board streams
module axi_ad7124_cmd
    import axi_ad7124_pkg::*;
#(
    parameter int NUM_OF_BOARD = 6
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             start,
    input  logic [12:0]      start_addr,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [11:0]      words_done,
    axi_ad7124_cmd_if.master io
);

    localparam logic [3:0] BOARD_LIMIT = 4'(NUM_OF_BOARD);

    cmd_state_t  state_q, state_d;
    logic [12:0] addr_q;
    logic [31:0] cmd_q;
    logic [1:0]  idx_q;
    logic        abort_q;
    logic        abort_pend;
    logic        done_d, error_d;
    logic        ch_valid, ch_ready;
    logic [7:0]  ch_data;
    logic [2:0]  rd_nbytes, rd_board;
    logic        rd_bad;
    logic        last_byte;

    assign rd_nbytes  = io.bram_rddata[CMD_NBYTES_LSB +: CMD_NBYTES_W];
    assign rd_board   = io.bram_rddata[CMD_BOARD_LSB +: CMD_BOARD_W];
    assign rd_bad     = (rd_nbytes > 3'(MAX_BYTES)) || ({1'b0, rd_board} >= BOARD_LIMIT);
    assign abort_pend = abort_q | abort;
    assign last_byte  = (({1'b0, idx_q} + 3'd1) == cmd_q[CMD_NBYTES_LSB +: CMD_NBYTES_W]);
    assign busy       = (state_q != IDLE);
    assign ch_valid   = (state_q == SEND);

    assign io.bram_clk    = aclk;
    assign io.bram_rst    = ~aresetn;
    assign io.bram_we     = 4'h0;
    assign io.bram_wrdata = 32'h0;
    assign io.bram_en     = (state_q == FETCH);
    assign io.bram_addr   = (state_q == FETCH) ? addr_q : 13'h0;

    always_comb begin
        ch_data = 8'h00;
        if (state_q == SEND) begin
            case (idx_q)
                2'd0:    ch_data = cmd_q[23:16];
                2'd1:    ch_data = cmd_q[15:8];
                default: ch_data = cmd_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = FETCH;
            FETCH: state_d = LATCH;
            LATCH: begin
                // A malformed word is reported as an error even if it also carries LAST.
                if (rd_bad || abort_pend) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else if (rd_nbytes == 3'd0) begin
                    state_d = NEXT;
                end else begin
                    state_d = SEND;
                end
            end
            SEND:  if (ch_ready && last_byte) state_d = NEXT;
            NEXT: begin
                if (cmd_q[CMD_LAST_BIT]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (abort_pend || (words_done == MAX_RUN_WORDS)) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            addr_q     <= 13'h0;
            cmd_q      <= 32'h0;
            idx_q      <= 2'd0;
            abort_q    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            words_done <= 12'd0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
            error   <= error_d;
            if (state_q == IDLE) abort_q <= 1'b0;
            else if (abort)      abort_q <= 1'b1;
            if (state_q == IDLE && start) begin
                addr_q     <= start_addr & 13'h1FFC;
                words_done <= 12'd0;
            end
            if (state_q == LATCH) begin
                cmd_q      <= io.bram_rddata;
                words_done <= words_done + 12'd1;
                idx_q      <= 2'd0;
            end
            if (state_q == SEND && ch_ready) idx_q <= idx_q + 2'd1;
            // 13-bit address wraps 0x1FFC -> 0x0000 on its own.
            if (state_q == NEXT && state_d == FETCH) addr_q <= addr_q + 13'd4;
        end
    end

    axi_ad7124_cmd_demux #(
        .NUM_OF_BOARD(NUM_OF_BOARD)
    ) u_demux (
        .valid    (ch_valid),
        .data     (ch_data),
        .ready    (ch_ready),
        .sel      (cmd_q[CMD_SEL_BIT]),
        .board    (cmd_q[CMD_BOARD_LSB +: CMD_BOARD_W]),
        .tc_valid (io.tc_sdo_valid),
        .tc_data  (io.tc_sdo_data),
        .tc_ready (io.tc_sdo_ready),
        .rtd_valid(io.rtd_sdo_valid),
        .rtd_data (io.rtd_sdo_data),
        .rtd_ready(io.rtd_sdo_ready)
    );

endmodule

// File: tb/tb_axi_ad7124_cmd.sv
// tb/tb_axi_ad7124_cmd.sv - directed scoreboard bench for the AD7124 command sequencer
module tb_axi_ad7124_cmd;

    localparam int NB = 6;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start;
    logic [12:0] start_addr;
    logic        abort;
    logic        busy, done, error;
    logic [11:0] words_done;

    axi_ad7124_cmd_if #(.NUM_OF_BOARD(NB)) io ();

    axi_ad7124_cmd #(.NUM_OF_BOARD(NB)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start     (start),
        .start_addr(start_addr),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .words_done(words_done),
        .io        (io.master)
    );

    always #5 aclk = ~aclk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int start_cyc;
    int first_valid_cyc;
    int done_cyc;
    int done_cnt, err_cnt, valid_cycles;
    int hold_viol = 0;
    int multi_viol = 0;
    int nv;
    logic        any_v;
    logic [31:0] mem [2048];
    logic [11:0] exp_q [$];
    logic [11:0] obs_q [$];
    logic [12:0] fetch_q [$];
    logic        vv [16];
    logic        rr [16];
    logic [7:0]  dd [16];
    logic        stall_prev [16];
    logic [7:0]  stall_data [16];

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk) begin
        if (io.bram_en) begin
            io.bram_rddata <= mem[io.bram_addr[12:2]];
            fetch_q.push_back(io.bram_addr);
        end
    end

    // Stream monitor: records handshakes, stalls that change data or drop valid, and done/error pulses.
    always @(negedge aclk) begin
        if (!aresetn) begin
            for (int c = 0; c < 16; c++) stall_prev[c] = 1'b0;
        end else begin
            for (int c = 0; c < 16; c++) begin
                vv[c] = 1'b0; rr[c] = 1'b0; dd[c] = 8'h00;
            end
            for (int b = 0; b < NB; b++) begin
                vv[b] = io.tc_sdo_valid[b];  rr[b] = io.tc_sdo_ready[b];  dd[b] = io.tc_sdo_data[b];
                vv[8+b] = io.rtd_sdo_valid[b]; rr[8+b] = io.rtd_sdo_ready[b]; dd[8+b] = io.rtd_sdo_data[b];
            end
            any_v = 1'b0;
            nv = 0;
            for (int c = 0; c < 16; c++) begin
                if (vv[c]) begin any_v = 1'b1; nv++; end
                if (vv[c] && rr[c]) obs_q.push_back({4'(c), dd[c]});
                if (stall_prev[c] && (!vv[c] || dd[c] != stall_data[c])) hold_viol++;
                stall_prev[c] = vv[c] && !rr[c];
                stall_data[c] = dd[c];
            end
            if (nv > 1) multi_viol++;
            if (any_v) begin
                valid_cycles++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (error) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_run();
        obs_q.delete();
        fetch_q.delete();
        exp_q.delete();
        done_cnt = 0; err_cnt = 0; valid_cycles = 0;
        first_valid_cyc = -1; done_cyc = -1;
    endtask

    task automatic push_exp(input logic [3:0] ch, input logic [7:0] b);
        exp_q.push_back({ch, b});
    endtask

    task automatic pulse_start(input logic [12:0] a);
        @(posedge aclk); #1;
        start_addr = a;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while ((done_cnt + err_cnt) == 0 && n < 300) begin
            @(negedge aclk);
            n++;
        end
        check({tag, "_end_seen"}, 32'(n < 300), 32'd1);
        repeat (4) @(negedge aclk);
    endtask

    task automatic check_stream(input string tag);
        logic [11:0] e, o;
        check({tag, "_byte_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_byte"}, 32'(o), 32'(e));
        end
    endtask

    task automatic wait_bytes(input string tag, input int cnt);
        int n;
        n = 0;
        while (obs_q.size() < cnt && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check(tag, 32'(n < 50), 32'd1);
    endtask

    initial begin
        int n;
        aresetn = 1'b0;
        start = 1'b0;
        start_addr = 13'h0;
        abort = 1'b0;
        io.tc_sdo_ready = '1;
        io.rtd_sdo_ready = '1;
        io.bram_rddata = 32'h0;
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[13'h100 >> 2]  = 32'h0300A1B2;
        mem[13'h104 >> 2]  = 32'hC9023400;
        mem[13'h200 >> 2]  = 32'h39AABBCC;
        mem[13'h300 >> 2]  = 32'h84112233;
        mem[13'h1FFC >> 2] = 32'h2ACAFE00;
        mem[0]             = 32'hD0000000;
        mem[13'h400 >> 2]  = 32'h5B112233;
        mem[13'h404 >> 2]  = 32'hC9023400;
        mem[13'h500 >> 2]  = 32'hA2556600;
        clear_run();

        repeat (3) @(posedge aclk); #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_words_done", 32'(words_done), 32'd0);
        check("rst_tc_valid", 32'(io.tc_sdo_valid), 32'd0);
        check("rst_rtd_valid", 32'(io.rtd_sdo_valid), 32'd0);
        check("rst_data", 32'(|io.tc_sdo_data | |io.rtd_sdo_data), 32'd0);
        check("rst_bram_en", 32'(io.bram_en), 32'd0);
        check("rst_bram_addr", 32'(io.bram_addr), 32'd0);
        check("rst_bram_we", 32'(io.bram_we), 32'd0);
        check("rst_bram_rst", 32'(io.bram_rst), 32'd1);
        aresetn = 1'b1;

        // Two-word list: TC0 bytes 00 A1 B2, then LAST on RTD1 byte 02.
        clear_run();
        push_exp(4'd0, 8'h00); push_exp(4'd0, 8'hA1); push_exp(4'd0, 8'hB2);
        push_exp(4'd9, 8'h02);
        pulse_start(13'h0101);
        check("t1_busy", 32'(busy), 32'd1);
        wait_end("t1");
        check_stream("t1");
        check("t1_first_valid_lat", 32'(first_valid_cyc - start_cyc), 32'd3);
        check("t1_done_lat", 32'(done_cyc - start_cyc), 32'd11);
        check("t1_done_cnt", 32'(done_cnt), 32'd1);
        check("t1_err_cnt", 32'(err_cnt), 32'd0);
        check("t1_words_done", 32'(words_done), 32'd2);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_fetch_cnt", 32'(fetch_q.size()), 32'd2);
        check("t1_fetch0", 32'(fetch_q[0]), 32'h100);
        check("t1_fetch1", 32'(fetch_q[1]), 32'h104);

        // Same list with TC0 ready low for 5 cycles while the second byte is offered.
        clear_run();
        push_exp(4'd0, 8'h00); push_exp(4'd0, 8'hA1); push_exp(4'd0, 8'hB2);
        push_exp(4'd9, 8'h02);
        pulse_start(13'h0100);
        wait_bytes("t2_first_byte_wait", 1);
        @(posedge aclk); #1;
        io.tc_sdo_ready[0] = 1'b0;
        repeat (5) @(posedge aclk);
        #1;
        io.tc_sdo_ready[0] = 1'b1;
        wait_end("t2");
        check_stream("t2");
        check("t2_done_lat", 32'(done_cyc - start_cyc), 32'd16);
        check("t2_done_cnt", 32'(done_cnt), 32'd1);
        check("t2_words_done", 32'(words_done), 32'd2);

        // BOARD = 7 is beyond the six fitted boards.
        clear_run();
        pulse_start(13'h0200);
        wait_end("t3");
        check_stream("t3");
        check("t3_err_cnt", 32'(err_cnt), 32'd1);
        check("t3_done_cnt", 32'(done_cnt), 32'd0);
        check("t3_valid_cycles", 32'(valid_cycles), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_words_done", 32'(words_done), 32'd1);

        // NBYTES = 4 together with LAST: error only.
        clear_run();
        pulse_start(13'h0300);
        wait_end("t3b");
        check("t3b_err_cnt", 32'(err_cnt), 32'd1);
        check("t3b_done_cnt", 32'(done_cnt), 32'd0);
        check("t3b_valid_cycles", 32'(valid_cycles), 32'd0);

        // Address wrap from the top of the 8 KB window back to 0.
        clear_run();
        push_exp(4'd5, 8'hCA); push_exp(4'd5, 8'hFE);
        pulse_start(13'h1FFC);
        wait_end("t4");
        check_stream("t4");
        check("t4_fetch_cnt", 32'(fetch_q.size()), 32'd2);
        check("t4_fetch0", 32'(fetch_q[0]), 32'h1FFC);
        check("t4_fetch1", 32'(fetch_q[1]), 32'h0000);
        check("t4_done_cnt", 32'(done_cnt), 32'd1);
        check("t4_words_done", 32'(words_done), 32'd2);

        // Abort while the second of three RTD3 bytes is offered.
        clear_run();
        push_exp(4'd11, 8'h11); push_exp(4'd11, 8'h22); push_exp(4'd11, 8'h33);
        pulse_start(13'h0400);
        wait_bytes("t5_first_byte_wait", 1);
        @(posedge aclk); #1;
        abort = 1'b1;
        @(posedge aclk); #1;
        abort = 1'b0;
        wait_end("t5");
        check_stream("t5");
        check("t5_err_cnt", 32'(err_cnt), 32'd1);
        check("t5_done_cnt", 32'(done_cnt), 32'd0);
        check("t5_fetch_cnt", 32'(fetch_q.size()), 32'd1);
        check("t5_words_done", 32'(words_done), 32'd1);

        // Reset while TC4 valid is stalled, then a clean rerun.
        clear_run();
        io.tc_sdo_ready[4] = 1'b0;
        pulse_start(13'h0500);
        n = 0;
        while (!io.tc_sdo_valid[4] && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("t6_valid_wait", 32'(n < 50), 32'd1);
        @(posedge aclk); #1;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        check("t6_tc_valid_after_rst", 32'(io.tc_sdo_valid), 32'd0);
        check("t6_rtd_valid_after_rst", 32'(io.rtd_sdo_valid), 32'd0);
        check("t6_busy_after_rst", 32'(busy), 32'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        io.tc_sdo_ready[4] = 1'b1;
        clear_run();
        push_exp(4'd4, 8'h55); push_exp(4'd4, 8'h66);
        pulse_start(13'h0500);
        wait_end("t6");
        check_stream("t6");
        check("t6_done_cnt", 32'(done_cnt), 32'd1);
        check("t6_words_done", 32'(words_done), 32'd1);

        check("hold_violations", 32'(hold_viol), 32'd0);
        check("multi_valid", 32'(multi_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
